// File: rtl/graph_rd_arb.sv
// graph_rd_arb: round-robin share of one AXI4 read master, one burst in flight, R beats routed to the grantee.
// Optional perf counters (io_cnt_busy/io_cnt_beats/io_cnt_clr) enabled by GRAPH_RD_ARB_PERF_EN.
module graph_rd_arb #(
  parameter int NUM_REQ = 3,
  parameter int ID_W = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     io_req_arvalid,
  output logic [NUM_REQ-1:0]     io_req_arready,
  input  logic [64*NUM_REQ-1:0]  io_req_araddr,
  input  logic [8*NUM_REQ-1:0]   io_req_arlen,
  output logic [NUM_REQ-1:0]     io_req_rvalid,
  input  logic [NUM_REQ-1:0]     io_req_rready,
  output logic [511:0]           io_req_rdata,
  output logic                   io_req_rlast,
  output logic [1:0]             io_req_rresp,
  output logic                   io_axi_arvalid,
  input  logic                   io_axi_arready,
  output logic [63:0]            io_axi_araddr,
  output logic [ID_W-1:0]        io_axi_arid,
  output logic [7:0]             io_axi_arlen,
  output logic [2:0]             io_axi_arsize,
  output logic [1:0]             io_axi_arburst,
  input  logic                   io_axi_rvalid,
  output logic                   io_axi_rready,
  input  logic [511:0]           io_axi_rdata,
  input  logic [ID_W-1:0]        io_axi_rid,
  input  logic [1:0]             io_axi_rresp,
  input  logic                   io_axi_rlast,
  output logic                   io_busy,
  output logic [2:0]             io_grant
`ifdef GRAPH_RD_ARB_PERF_EN
  ,
  input  logic                   io_cnt_clr,
  output logic [31:0]            io_cnt_busy,
  output logic [31:0]            io_cnt_beats
`endif
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state, state_d;
  logic [2:0] last_grant, grant, win;
  logic [63:0] addr_q;
  logic [7:0] len_q;
  logic found, accept, r_done;
  logic [NUM_REQ-1:0] grant_mask;
  // search starts just after the previous winner so every requester is served within NUM_REQ bursts
  always_comb begin
    win = last_grant;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && io_req_arvalid[(int'(last_grant) + k) % NUM_REQ]) begin
        win = 3'((int'(last_grant) + k) % NUM_REQ);
        found = 1'b1;
      end
    end
  end
  assign accept = state == IDLE && found;
  assign grant_mask = NUM_REQ'(1) << grant;
  assign r_done = state == DATA && io_axi_rvalid && io_axi_rready && io_axi_rlast;
  always_comb begin
    state_d = accept ? ADDR : (state == ADDR && io_axi_arready) ? DATA : r_done ? IDLE : state;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      last_grant <= 3'(NUM_REQ - 1);
      grant <= '0;
      addr_q <= '0;
      len_q <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        grant <= win;
        addr_q <= io_req_araddr[64*win +: 64];
        len_q <= io_req_arlen[8*win +: 8];
      end
      if (r_done) last_grant <= grant;
    end
  end
  assign io_req_arready = accept ? NUM_REQ'(1) << win : '0;
  assign io_axi_arvalid = state == ADDR;
  assign io_axi_araddr = addr_q;
  assign io_axi_arlen = len_q;
  assign io_axi_arid = ID_W'(grant);
  assign io_axi_arsize = 3'b110;
  assign io_axi_arburst = 2'b01;
  assign io_req_rvalid = (state == DATA && io_axi_rvalid) ? grant_mask : '0;
  assign io_axi_rready = state == DATA && |(io_req_rready & grant_mask);
  assign io_req_rdata = io_axi_rdata;
  assign io_req_rlast = io_axi_rlast;
  assign io_req_rresp = io_axi_rresp;
  assign io_busy = state != IDLE;
  assign io_grant = grant;
`ifdef GRAPH_RD_ARB_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      io_cnt_busy <= '0;
      io_cnt_beats <= '0;
    end else if (io_cnt_clr) begin
      io_cnt_busy <= '0;
      io_cnt_beats <= '0;
    end else begin
      if (io_busy && !(&io_cnt_busy)) io_cnt_busy <= io_cnt_busy + 32'd1;
      if (io_axi_rvalid && io_axi_rready && !(&io_cnt_beats)) io_cnt_beats <= io_cnt_beats + 32'd1;
    end
  end
`endif
endmodule

// File: doc/graph_rd_arb.md
# graph_rd_arb

Round-robin arbiter that shares the single 512-bit AXI4 read master of the graph kernel between `NUM_REQ` internal fetch engines (pointer fetch, edge/data fetch, frontier fetch). It sits between the fetch engines and the kernel's `io_axi_ar*`/`io_axi_r*` ports. It holds one burst in flight at a time and routes R beats back to the granted requester. It also exposes grant status and optional performance counters to the kernel control logic.

## Interface
Parameters:
- `NUM_REQ`, 3: number of requesters, 2..8
- `ID_W`, 1: AXI ID width; `io_axi_arid` carries the grant index truncated to `ID_W`

Ports:
- `clk`  in  1  sole clock
- `reset`  in  1  asynchronous, active-low reset
- `io_req_arvalid`  in  NUM_REQ  per-requester read request
- `io_req_arready`  out  NUM_REQ  request accepted (one-hot pulse)
- `io_req_araddr`  in  64*NUM_REQ  burst start address, requester i at [64i+63:64i]
- `io_req_arlen`  in  8*NUM_REQ  AXI len (beats-1), requester i at [8i+7:8i]
- `io_req_rvalid`  out  NUM_REQ  R beat valid, only granted bit may be 1
- `io_req_rready`  in  NUM_REQ  requester R ready
- `io_req_rdata`  out  512  broadcast R data
- `io_req_rlast`  out  1  broadcast R last
- `io_req_rresp`  out  2  broadcast R resp
- `io_axi_arvalid/arready/araddr/arid/arlen/arsize/arburst`  AXI AR master (64-bit addr, 8-bit len)
- `io_axi_rvalid/rready/rdata/rid/rresp/rlast`  AXI R master (512-bit data)
- `io_busy`  out  1  state != IDLE
- `io_grant`  out  3  index of current/last grant

## Operation
- States: IDLE, ADDR, DATA.
- IDLE:
  - If any `io_req_arvalid`, select the winner round-robin, starting from `last_grant+1` modulo NUM_REQ.
  - Drive `io_req_arready[win]=1` combinationally in that cycle.
  - Capture addr/len into registers, set `grant=win`, go to ADDR.
- ADDR:
  - `io_axi_arvalid=1` with the registered addr/len, `arid=grant[ID_W-1:0]`, `arsize=3'b110`, `arburst=2'b01`.
  - On `arready`, go to DATA.
- DATA:
  - `io_req_rvalid[grant]=io_axi_rvalid`; all other bits 0.
  - `io_axi_rready=io_req_rready[grant]`.
  - On `rvalid & rready & rlast`, set `last_grant=grant` and go to IDLE.
- `io_axi_rready=0` outside DATA. `io_axi_rid` is ignored; with a single burst in flight, ordering is guaranteed.
- `rdata`, `rlast` and `rresp` pass through combinationally in every state.
- Requesters must hold `arvalid`/addr/len stable until `arready` (AXI rule). The block never drops a request.
- `rresp != OKAY` is forwarded unchanged. The burst still completes on `rlast`.
- Only `rlast` closes the burst; no beat counting is done. A burst terminated early by the slave is followed exactly.

## Timing
- Reset values:
  - state IDLE, `last_grant = NUM_REQ-1` (requester 0 wins first), `io_grant=0`, `io_busy=0`.
  - All `io_req_arready`/`io_req_rvalid`=0, `io_axi_arvalid=0`, `io_axi_rready=0`.
  - `io_axi_araddr=0`, `io_axi_arlen=0`.
- Latency:
  - Request accepted in the same cycle it is seen in IDLE.
  - `io_axi_arvalid` rises 1 cycle later.
- R path: zero latency, purely combinational routing.
- Back-to-back bursts: one IDLE cycle between the `rlast` handshake and the next `arready` pulse.
- Simultaneous requests: exactly one `io_req_arready` bit per IDLE cycle. Every requester is served within NUM_REQ bursts.
- `io_axi_arready` already high in ADDR: leaves ADDR after 1 cycle.
- Reset asserted mid-burst:
  - All outputs return to reset values asynchronously.
  - The in-flight AXI burst is abandoned. The kernel must reset the memory side together with this block.

## Configuration
- `GRAPH_RD_ARB_PERF_EN` defined:
  - Adds outputs `io_cnt_busy` (32b, counts cycles with state != IDLE) and `io_cnt_beats` (32b, counts R handshakes).
  - Both counters saturate at 0xFFFFFFFF, are cleared by reset, and are also cleared synchronously on input `io_cnt_clr` (1b, added by the same macro).
- Not defined: these ports and counters are absent. Arbitration behaviour is identical.

## Test plan
- Single request, req1 addr 0x1000 len 3, slave arready immediate, 4 beats with rlast on beat 4 -> `io_axi_araddr=0x1000`, `arlen=3`, `arid=1`. `io_req_rvalid=3'b010` for 4 beats, then `io_busy=0`.
- All 3 requesters assert continuously for 6 bursts of len 0 -> grant order 0,1,2,0,1,2. One `arready` pulse each, never two bits set.
- Backpressure: req0 len 7, `io_req_rready[0]` toggled every other cycle -> `io_axi_rready` mirrors it. All 8 beats delivered in order. `io_req_rvalid` for other requesters stays 0.
- Slave holds arready low 5 cycles -> `arvalid` held 6 cycles with stable addr/len/id. No R routing before DATA.
- Reset asserted in DATA after 2 of 4 beats -> all outputs at reset values in the same cycle. After release, a req2 request wins first when req0 is idle, and req0 wins first when req0 and req2 request together.
- With `GRAPH_RD_ARB_PERF_EN`: two len-3 bursts -> `io_cnt_beats=8`, `io_cnt_busy` equals the cycles spent outside IDLE. Pulsing `io_cnt_clr` -> both counters 0 on the next cycle.
